// File: rtl/video_source_mux_pkg.sv
// rtl/video_source_mux_pkg.sv - shared video bus type and source-switch FSM states
package video_source_mux_pkg;

    typedef struct packed {
        logic       vsync;
        logic       hsync;
        logic       display_enable;
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } t_video_bus;

    typedef enum logic {
        LOCKED  = 1'b0,
        PENDING = 1'b1
    } t_mux_state;

endpackage

// File: rtl/video_colour_reduce.sv
// rtl/video_colour_reduce.sv - 8-bit colour channel to W bits; rounds when VIDEO_SOURCE_MUX_ROUND_EN is defined
module video_colour_reduce #(
    parameter int W = 6
) (
    input  logic [7:0]   value,
    output logic [W-1:0] reduced
);

    generate
        if (W == 8) begin : g_pass
            assign reduced = value;
        end else begin : g_reduce
`ifdef VIDEO_SOURCE_MUX_ROUND_EN
            logic [W:0] sum;
            // Round on the first dropped bit; a carry out means the channel is already at full scale.
            assign sum     = {1'b0, value[7 -: W]} + {{W{1'b0}}, value[7-W]};
            assign reduced = sum[W] ? {W{1'b1}} : sum[W-1:0];
`else
            assign reduced = value[7 -: W];
`endif
        end
    endgenerate

endmodule

// File: rtl/video_source_mux.sv
// rtl/video_source_mux.sv - vsync-aligned video source switch with LCD colour reduction (option: VIDEO_SOURCE_MUX_ROUND_EN)
module video_source_mux
    import video_source_mux_pkg::*;
#(
    parameter int NUM_SOURCES     = 2,
    parameter int RED_WIDTH       = 6,
    parameter int GREEN_WIDTH     = 7,
    parameter int BLUE_WIDTH      = 6,
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SOURCES-1:0]   video_in__vsync,
    input  logic [NUM_SOURCES-1:0]   video_in__hsync,
    input  logic [NUM_SOURCES-1:0]   video_in__display_enable,
    input  logic [8*NUM_SOURCES-1:0] video_in__red,
    input  logic [8*NUM_SOURCES-1:0] video_in__green,
    input  logic [8*NUM_SOURCES-1:0] video_in__blue,
    input  logic [2:0]               select,
    output logic                     lcd__vsync,
    output logic                     lcd__hsync,
    output logic                     lcd__display_enable,
    output logic [RED_WIDTH-1:0]     lcd__red,
    output logic [GREEN_WIDTH-1:0]   lcd__green,
    output logic [BLUE_WIDTH-1:0]    lcd__blue,
    output logic [2:0]               current_source,
    output logic                     switch_pending
);

    localparam int              CW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      NUM_SRC      = 4'(NUM_SOURCES);
    localparam logic            SYNC_INV     = (SYNC_ACTIVE_LOW != 0);

    t_mux_state     state, state_next;
    logic [2:0]     current_next, target_source, target_next;
    logic [CW-1:0]  counter, counter_next;
    logic           prev_vsync;
    t_video_bus     src_bus [8];
    t_video_bus     sel_bus;
    logic           sel_valid, vsync_rise;
    logic [RED_WIDTH-1:0]   red_r;
    logic [GREEN_WIDTH-1:0] green_r;
    logic [BLUE_WIDTH-1:0]  blue_r;

    // Unused slots read as an idle bus so a 3-bit index never leaves the array.
    generate
        for (genvar i = 0; i < 8; i++) begin : g_src
            if (i < NUM_SOURCES) begin : g_used
                assign src_bus[i] = '{vsync:          video_in__vsync[i],
                                      hsync:          video_in__hsync[i],
                                      display_enable: video_in__display_enable[i],
                                      red:            video_in__red[8*i +: 8],
                                      green:          video_in__green[8*i +: 8],
                                      blue:           video_in__blue[8*i +: 8]};
            end else begin : g_idle
                assign src_bus[i] = '0;
            end
        end
    endgenerate

    assign sel_bus        = src_bus[current_source];
    assign sel_valid      = {1'b0, select} < NUM_SRC;
    assign vsync_rise     = sel_bus.vsync && !prev_vsync;
    assign switch_pending = (state == PENDING);

    always_comb begin
        state_next   = state;
        current_next = current_source;
        target_next  = target_source;
        counter_next = counter;
        case (state)
            LOCKED: begin
                if (sel_valid && select != current_source) begin
                    state_next   = PENDING;
                    target_next  = select;
                    counter_next = '0;
                end
            end
            PENDING: begin
                if (sel_valid && select == current_source) begin
                    state_next = LOCKED;
                end else begin
                    if (sel_valid && select != target_source) begin
                        target_next = select;
                    end
                    if (vsync_rise || counter == TIMEOUT_LAST) begin
                        current_next = target_next;
                        state_next   = LOCKED;
                    end else begin
                        counter_next = counter + CW'(1);
                    end
                end
            end
            default: state_next = LOCKED;
        endcase
    end

    video_colour_reduce #(.W(RED_WIDTH))   u_red   (.value(sel_bus.red),   .reduced(red_r));
    video_colour_reduce #(.W(GREEN_WIDTH)) u_green (.value(sel_bus.green), .reduced(green_r));
    video_colour_reduce #(.W(BLUE_WIDTH))  u_blue  (.value(sel_bus.blue),  .reduced(blue_r));

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= LOCKED;
            current_source      <= '0;
            target_source       <= '0;
            counter             <= '0;
            prev_vsync          <= 1'b0;
            lcd__vsync          <= SYNC_INV;
            lcd__hsync          <= SYNC_INV;
            lcd__display_enable <= 1'b0;
            lcd__red            <= '0;
            lcd__green          <= '0;
            lcd__blue           <= '0;
        end else begin
            state               <= state_next;
            current_source      <= current_next;
            target_source       <= target_next;
            counter             <= counter_next;
            prev_vsync          <= sel_bus.vsync;
            lcd__vsync          <= sel_bus.vsync ^ SYNC_INV;
            lcd__hsync          <= sel_bus.hsync ^ SYNC_INV;
            lcd__display_enable <= sel_bus.display_enable;
            lcd__red            <= sel_bus.display_enable ? red_r   : '0;
            lcd__green          <= sel_bus.display_enable ? green_r : '0;
            lcd__blue           <= sel_bus.display_enable ? blue_r  : '0;
        end
    end

endmodule

// File: tb/tb_video_source_mux.sv
// tb/tb_video_source_mux.sv - directed self-checking bench for video_source_mux
module tb_video_source_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  vin_vsync, vin_hsync, vin_de;
    logic [15:0] vin_red, vin_green, vin_blue;
    logic [2:0]  select;

    logic       a_vsync, a_hsync, a_de, a_pending;
    logic [5:0] a_red, a_blue;
    logic [6:0] a_green;
    logic [2:0] a_cur;
    logic       t_vsync, t_hsync, t_de, t_pending;
    logic [5:0] t_red, t_blue;
    logic [6:0] t_green;
    logic [2:0] t_cur;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    video_source_mux dut (
        .clk(clk), .reset(reset),
        .video_in__vsync(vin_vsync), .video_in__hsync(vin_hsync),
        .video_in__display_enable(vin_de),
        .video_in__red(vin_red), .video_in__green(vin_green), .video_in__blue(vin_blue),
        .select(select),
        .lcd__vsync(a_vsync), .lcd__hsync(a_hsync), .lcd__display_enable(a_de),
        .lcd__red(a_red), .lcd__green(a_green), .lcd__blue(a_blue),
        .current_source(a_cur), .switch_pending(a_pending)
    );

    video_source_mux #(.TIMEOUT_CYCLES(16)) dut_t (
        .clk(clk), .reset(reset),
        .video_in__vsync(vin_vsync), .video_in__hsync(vin_hsync),
        .video_in__display_enable(vin_de),
        .video_in__red(vin_red), .video_in__green(vin_green), .video_in__blue(vin_blue),
        .select(select),
        .lcd__vsync(t_vsync), .lcd__hsync(t_hsync), .lcd__display_enable(t_de),
        .lcd__red(t_red), .lcd__green(t_green), .lcd__blue(t_blue),
        .current_source(t_cur), .switch_pending(t_pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_7e;
        bit         pend_ok;
        reset = 1'b1; select = 3'd0;
        vin_vsync = '0; vin_hsync = '0; vin_de = '0;
        vin_red = '0; vin_green = '0; vin_blue = '0;
        cyc(5);
        check("rst_cur",     a_cur, 0);
        check("rst_vsync",   a_vsync, 1);
        check("rst_hsync",   a_hsync, 1);
        check("rst_de",      a_de, 0);
        check("rst_red",     a_red, 0);
        check("rst_pending", a_pending, 0);
        reset = 1'b0;

        // Source 0 colour path, source 1 preloaded with a distinct pattern.
        vin_de = 2'b11; vin_hsync = 2'b01;
        vin_red = 16'hA4_FF; vin_green = 16'h00_FF; vin_blue = 16'h00_FF;
        cyc(1);
        check("red_ff",   a_red, 6'h3F);
        check("green_ff", a_green, 7'h7F);
        check("blue_ff",  a_blue, 6'h3F);
        check("hsync_inv", a_hsync, 0);
        check("vsync_idle", a_vsync, 1);
        vin_de = 2'b10;
        cyc(1);
        check("red_de0", a_red, 0);
        check("de_out0", a_de, 0);
        vin_de = 2'b11; vin_red = 16'hA4_7E;
        cyc(1);
`ifdef VIDEO_SOURCE_MUX_ROUND_EN
        exp_7e = 8'h20;
`else
        exp_7e = 8'h1F;
`endif
        check("red_7e", a_red, 32'(exp_7e));
        vin_red = 16'hA4_FE;
        cyc(1);
        check("red_fe", a_red, 6'h3F);

        // Invalid select is ignored.
        select = 3'd5;
        cyc(3);
        check("inval_pending", a_pending, 0);
        check("inval_cur",     a_cur, 0);

        // Switch 0->1 aligned to a source 0 vsync rise 100 cycles later.
        select = 3'd1;
        pend_ok = 1'b1;
        for (int k = 0; k < 100; k++) begin
            cyc(1);
            if (a_pending !== 1'b1 || a_cur !== 3'd0) pend_ok = 1'b0;
        end
        check("pend_100", 32'(pend_ok), 1);
        vin_vsync = 2'b01;
        cyc(1);
        check("sw_cur",     a_cur, 1);
        check("sw_pending", a_pending, 0);
        check("sw_red_old", a_red, 6'h3F);
        check("sw_vs_old",  a_vsync, 0);
        cyc(1);
        check("sw_red_new", a_red, 6'h29);
        check("sw_vs_new",  a_vsync, 1);
        check("t_cur_after_timeout", t_cur, 1);

        // Rising edge in the cycle LOCKED first sees the request does not switch.
        select = 3'd0; vin_vsync = 2'b11;
        cyc(1);
        check("edge_first_cur",  a_cur, 1);
        check("edge_first_pend", a_pending, 1);
        cyc(1);
        check("edge_held_cur", a_cur, 1);
        vin_vsync = 2'b01;
        cyc(1);
        vin_vsync = 2'b11;
        cyc(1);
        check("back_cur", a_cur, 0);
        vin_vsync = 2'b00;
        cyc(20);
        check("t_back_cur", t_cur, 0);

        // Timeout of 16: switch lands on the 17th clock after select changes.
        select = 3'd1;
        cyc(16);
        check("to_16", t_cur, 0);
        check("to_16_pend", t_pending, 1);
        cyc(1);
        check("to_17", t_cur, 1);
        check("to_17_pend", t_pending, 0);

        // Cancel wins over a coincident vsync rise.
        check("cancel_pre", a_pending, 1);
        select = 3'd0; vin_vsync = 2'b01;
        cyc(1);
        check("cancel_cur",  a_cur, 0);
        check("cancel_pend", a_pending, 0);
        cyc(1);
        check("cancel_hold", a_cur, 0);

        // Reset abandons a pending switch.
        vin_vsync = 2'b00;
        select = 3'd1;
        cyc(1);
        check("rp_pend", a_pending, 1);
        reset = 1'b1; select = 3'd0;
        cyc(1);
        reset = 1'b0; vin_vsync = 2'b01;
        cyc(2);
        check("rp_cur",  a_cur, 0);
        check("rp_pend_clr", a_pending, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
